inst_fetch_unit: RTL and testbench

Instruction fetch and issue stage that sits directly upstream of the S-Machine instruction interpreter. It keeps its own fetch address and reads 16-bit instructions from program memory over a req/ack handshake. It presents each instruction on `inst` with a one-cycle `start` pulse, then waits for the interpreter's `done` before fetching the next one. It also supports free-run and single-step modes, a HALT opcode, and a watchdog on `done`.

---
 rtl/smachine_pkg.sv | 33 +++
 rtl/fetch_watchdog.sv | 35 +++
 rtl/inst_fetch_unit.sv | 112 +++++++++++
 tb/tb_inst_fetch_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/smachine_pkg.sv
// Shared S-Machine definitions: fetch FSM states, opcode map and datapath widths.
package smachine_pkg;

   localparam int SM_ADDR_W = 8;
   localparam int SM_INST_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_ISSUE = 3'd2,
      ST_EXEC  = 3'd3,
      ST_HALT  = 3'd4,
      ST_ERR   = 3'd5
   } fetch_state_t;

   localparam logic [3:0] OP_LD   = 4'h0;
   localparam logic [3:0] OP_ST   = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_SUB  = 4'h3;
   localparam logic [3:0] OP_AND  = 4'h4;
   localparam logic [3:0] OP_OR   = 4'h5;
   localparam logic [3:0] OP_XOR  = 4'h6;
   localparam logic [3:0] OP_NOT  = 4'h7;
   localparam logic [3:0] OP_SHL  = 4'h8;
   localparam logic [3:0] OP_SHR  = 4'h9;
   localparam logic [3:0] OP_JMP  = 4'hA;
   localparam logic [3:0] OP_JZ   = 4'hB;
   localparam logic [3:0] OP_JNZ  = 4'hC;
   localparam logic [3:0] OP_INC  = 4'hD;
   localparam logic [3:0] OP_CLR  = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;

endpackage

// File: rtl/fetch_watchdog.sv
// Execution watchdog: counts enabled cycles since the last clear and flags the
// cycle whose increment makes the count reach DONE_TIMEOUT.
module fetch_watchdog #(
   parameter int DONE_TIMEOUT = 15
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam int CNT_W = (DONE_TIMEOUT < 1) ? 1 : $clog2(DONE_TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i)
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   // Fires on the edge where the count would become DONE_TIMEOUT.
   assign tc_o = en_i && (cnt_q == CNT_W'(DONE_TIMEOUT - 1));

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch/issue stage feeding the S-Machine interpreter: fetches over
// req/ack, issues with a start pulse, waits for done, supports run/step/HALT.
module inst_fetch_unit
   import smachine_pkg::*;
#(
   parameter int               ADDR_W       = SM_ADDR_W,
   parameter int               INST_W       = SM_INST_W,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0,
   parameter logic [3:0]       HALT_OP      = OP_HALT,
   parameter int               DONE_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              step,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [INST_W-1:0] imem_data,
   output logic [INST_W-1:0] inst,
   output logic              start,
   input  logic              done,
   output logic [ADDR_W-1:0] fetch_pc,
   output logic              busy,
   output logic              halted,
   output logic              err,
   output fetch_state_t      dbg_state
);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [INST_W-1:0] inst_q, inst_d;
   logic              step_q, step_d;
   logic              wd_clr, wd_en, wd_tc;

   fetch_watchdog #(.DONE_TIMEOUT(DONE_TIMEOUT)) u_watchdog (
      .clk_i (clk),
      .rst_i (rst),
      .clr_i (wd_clr),
      .en_i  (wd_en),
      .tc_o  (wd_tc)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      step_d  = step_q;
      wd_clr  = 1'b0;
      wd_en   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (run) begin
               state_d = ST_REQ;
               step_d  = 1'b0;
            end else if (step) begin
               state_d = ST_REQ;
               step_d  = 1'b1;
            end
         end
         ST_REQ: begin
            if (imem_ack) begin
               inst_d  = imem_data;
               pc_d    = pc_q + ADDR_W'(1);
               state_d = (imem_data[INST_W-1 -: 4] == HALT_OP) ? ST_HALT : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            wd_clr  = 1'b1;
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            // done wins over a watchdog expiry in the same cycle.
            if (done) begin
               step_d  = 1'b0;
               state_d = (run && !step_q) ? ST_REQ : ST_IDLE;
            end else begin
               wd_en = 1'b1;
               if (wd_tc)
                  state_d = ST_ERR;
            end
         end
         default: state_d = state_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         inst_q  <= '0;
         step_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         step_q  <= step_d;
      end
   end

   // Outputs decode only registered state, so nothing is combinational from inputs.
   assign imem_req  = (state_q == ST_REQ);
   assign imem_addr = imem_req ? pc_q : '0;
   assign start     = (state_q == ST_ISSUE);
   assign busy      = (state_q == ST_REQ) || (state_q == ST_ISSUE) || (state_q == ST_EXEC);
   assign halted    = (state_q == ST_HALT);
   assign err       = (state_q == ST_ERR);
   assign inst      = inst_q;
   assign fetch_pc  = pc_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a memory/interpreter responder and an
// expected-instruction queue checked on every start pulse.
module tb_inst_fetch_unit;
   import smachine_pkg::*;

   logic         clk, rst, run, step;
   logic         imem_req, imem_ack, start, done, busy, halted, err;
   logic [7:0]   imem_addr, fetch_pc;
   logic [15:0]  imem_data, inst;
   fetch_state_t dbg_state;

   inst_fetch_unit dut (
      .clk(clk), .rst(rst), .run(run), .step(step),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_data(imem_data), .inst(inst), .start(start), .done(done),
      .fetch_pc(fetch_pc), .busy(busy), .halted(halted), .err(err),
      .dbg_state(dbg_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_tests = 0;
   int n_failed = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   logic [15:0] mem [256];
   logic [15:0] exp_q [$];
   logic [7:0]  addr_log [$];
   int          start_cyc [$];
   int          mem_lat = 0;
   int          done_delay = 1;
   int          req_wait = 0;
   int          done_cnt = 0;
   int          req_start_cyc = 0;
   int          ack_cyc = 0;
   int          starts = 0;
   logic        prev_start = 1'b0;
   logic [7:0]  held_addr = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Memory and interpreter responder plus start monitor, all on the falling edge.
   always @(negedge clk) begin
      if (rst) begin
         imem_ack = 1'b0; imem_data = '0; done = 1'b0;
         req_wait = 0; done_cnt = 0; prev_start = 1'b0;
      end else begin
         imem_ack = 1'b0;
         done = 1'b0;
         if (imem_req) begin
            if (req_wait > 0) check("addr_hold", {24'd0, imem_addr}, {24'd0, held_addr});
            else begin
               held_addr = imem_addr;
               req_start_cyc = cyc;
            end
            if (req_wait >= mem_lat) begin
               imem_ack = 1'b1;
               imem_data = mem[imem_addr];
               addr_log.push_back(imem_addr);
               ack_cyc = cyc;
               if (mem[imem_addr][15:12] != OP_HALT) exp_q.push_back(mem[imem_addr]);
               req_wait = 0;
            end else begin
               req_wait++;
            end
         end else begin
            req_wait = 0;
         end
         if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) done = 1'b1;
         end
         if (start) begin
            starts++;
            start_cyc.push_back(cyc);
            check("start_not_back_to_back", {31'd0, prev_start}, 32'd0);
            if (exp_q.size() == 0) check("unexpected_start", 32'd1, 32'd0);
            else check("issued_inst", {16'd0, inst}, {16'd0, exp_q.pop_front()});
            if (done_delay > 0) done_cnt = done_delay;
         end
         prev_start = start;
      end
   end

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; run = 1'b0; step = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      exp_q.delete(); addr_log.delete(); start_cyc.delete();
      starts = 0; mem_lat = 0; done_delay = 1;
      rst = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int err_cyc;
      rst = 1'b1; run = 1'b0; step = 1'b0;
      imem_ack = 1'b0; imem_data = '0; done = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 16'h1000 | 16'(i);
      repeat (3) @(posedge clk);
      #1;
      // Reset values
      check("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
      check("rst_pc", {24'd0, fetch_pc}, 32'd0);
      check("rst_inst", {16'd0, inst}, 32'd0);
      check("rst_outs", {26'd0, imem_req, imem_addr != 8'd0, start, busy, halted, err}, 32'd0);
      rst = 1'b0;

      // Free run with zero-wait memory, ending on HALT
      mem[0] = 16'h2A05; mem[1] = 16'h4000; mem[2] = 16'hF000;
      tick();
      run = 1'b1;
      for (int i = 0; i < 60 && !halted; i++) tick();
      check("fr_halted", {31'd0, halted}, 32'd1);
      check("fr_pc", {24'd0, fetch_pc}, 32'd3);
      check("fr_starts", starts, 32'd2);
      if (start_cyc.size() == 2) check("fr_spacing", start_cyc[1] - start_cyc[0], 32'd3);
      else check("fr_start_log", start_cyc.size(), 32'd2);
      check("fr_inst_captured", {16'd0, inst}, 32'h0000F000);
      check("fr_busy", {31'd0, busy}, 32'd0);
      run = 1'b0;
      repeat (5) tick();
      check("fr_stay_halted", {30'd0, halted, start}, 32'd2);
      check("fr_queue_empty", exp_q.size(), 32'd0);

      // Single step, second step during EXEC ignored
      do_reset();
      mem[0] = 16'h0C12; mem[1] = 16'h1111;
      done_delay = 3;
      step = 1'b1;
      tick();
      step = 1'b0;
      for (int i = 0; i < 20 && starts == 0; i++) tick();
      check("st_dbg_exec", {29'd0, dbg_state}, {29'd0, ST_EXEC});
      step = 1'b1;
      tick();
      step = 1'b0;
      repeat (15) tick();
      check("st_starts", starts, 32'd1);
      check("st_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
      check("st_pc", {24'd0, fetch_pc}, 32'd1);
      check("st_busy", {31'd0, busy}, 32'd0);

      // Late memory ack
      do_reset();
      mem[0] = 16'h1234; mem[1] = 16'hF000;
      mem_lat = 4;
      run = 1'b1;
      for (int i = 0; i < 30 && starts == 0; i++) tick();
      check("mw_req_to_ack", ack_cyc - req_start_cyc, 32'd4);
      if (start_cyc.size() > 0) check("mw_ack_to_start", start_cyc[0] - ack_cyc, 32'd1);
      else check("mw_start_seen", 32'd0, 32'd1);
      for (int i = 0; i < 30 && !halted; i++) tick();
      check("mw_halted", {31'd0, halted}, 32'd1);
      run = 1'b0;

      // Address wrap from FF to 00
      do_reset();
      for (int i = 0; i < 256; i++) mem[i] = 16'h1000 | 16'(i);
      run = 1'b1;
      for (int i = 0; i < 1000 && addr_log.size() < 258; i++) tick();
      run = 1'b0;
      for (int i = 0; i < 20 && busy; i++) tick();
      check("wr_fetches", addr_log.size() >= 258, 32'd1);
      if (addr_log.size() >= 258) begin
         check("wr_addr_fe", {24'd0, addr_log[254]}, 32'hFE);
         check("wr_addr_ff", {24'd0, addr_log[255]}, 32'hFF);
         check("wr_addr_00", {24'd0, addr_log[256]}, 32'h00);
         check("wr_addr_01", {24'd0, addr_log[257]}, 32'h01);
      end
      check("wr_idle", {29'd0, dbg_state}, {29'd0, ST_IDLE});
      check("wr_queue_empty", exp_q.size(), 32'd0);

      // Watchdog expiry
      do_reset();
      mem[0] = 16'h3333;
      done_delay = 0;
      run = 1'b1;
      err_cyc = 0;
      for (int i = 0; i < 60 && !err; i++) begin
         tick();
         if (err) err_cyc = cyc;
      end
      check("wd_err", {31'd0, err}, 32'd1);
      if (start_cyc.size() > 0) check("wd_latency", err_cyc - start_cyc[0], 32'd16);
      else check("wd_start_seen", 32'd0, 32'd1);
      check("wd_busy", {31'd0, busy}, 32'd0);
      run = 1'b0;
      repeat (10) tick();
      check("wd_sticky", {30'd0, err, busy}, 32'd2);
      do_reset();
      check("wd_cleared", {31'd0, err}, 32'd0);

      // Reset in the middle of a stalled request
      mem[0] = 16'h5000; mem[1] = 16'h5001; mem[2] = 16'h5002;
      done_delay = 1;
      run = 1'b1;
      for (int i = 0; i < 40 && addr_log.size() < 2; i++) tick();
      mem_lat = 10;
      for (int i = 0; i < 40 && !(imem_req && imem_addr == 8'd2); i++) tick();
      tick();
      check("mr_req_before", {31'd0, imem_req}, 32'd1);
      rst = 1'b1;
      #1;
      check("mr_req_dropped", {31'd0, imem_req}, 32'd0);
      check("mr_pc", {24'd0, fetch_pc}, 32'd0);
      run = 1'b0;
      do_reset();
      run = 1'b1;
      for (int i = 0; i < 20 && addr_log.size() < 1; i++) tick();
      if (addr_log.size() > 0) check("mr_first_addr", {24'd0, addr_log[0]}, 32'd0);
      else check("mr_fetch_seen", 32'd0, 32'd1);
      run = 1'b0;
      for (int i = 0; i < 20 && busy; i++) tick();
      check("mr_queue_empty", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
      $finish;
   end

endmodule
